wb_regfile: RTL and testbench

- 32-entry integer register file for the pipelined RV32I core: the consumer side of the writeback data path, reading the value selected at writeback into the architectural registers.
- Supplies the two decode-stage source operands, with write-through bypass.
- Holds a per-register load-pending scoreboard and raises a decode stall on a load-use hazard.

---
 rtl/wb_regfile.sv | 98 +++++++++
 tb/tb_wb_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback register file: 32 x DATA_W integer registers, two bypassed read ports,
// per-register load-pending scoreboard with load-use stall. Optional REGFILE_DEBUG_EN adds a raw debug read port and a writeback counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WbEnIn,
    input  logic [ADDR_W-1:0] WbAddrIn,
    input  logic [DATA_W-1:0] WbDataIn,
    input  logic [ADDR_W-1:0] Rs1AddrIn,
    input  logic [ADDR_W-1:0] Rs2AddrIn,
    input  logic              Rs1UseIn,
    input  logic              Rs2UseIn,
    input  logic              IssueEnIn,
    input  logic              IssueLoadIn,
    input  logic [ADDR_W-1:0] IssueRdIn,
    output logic [DATA_W-1:0] Rs1DataOut,
    output logic [DATA_W-1:0] Rs2DataOut,
    output logic              StallOut
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [ADDR_W-1:0] DbgAddrIn,
    output logic [DATA_W-1:0] DbgDataOut,
    output logic [31:0]       WbCountOut
`endif
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic              wr_en;
    logic              bypass1;
    logic              bypass2;

    assign wr_en   = WbEnIn && (WbAddrIn != '0);
    assign bypass1 = WbEnIn && (WbAddrIn == Rs1AddrIn);
    assign bypass2 = WbEnIn && (WbAddrIn == Rs2AddrIn);

    // Set is applied after clear so a new load to the register retiring this cycle stays pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[WbAddrIn] = 1'b0;
        end
        if (IssueEnIn && IssueLoadIn && (IssueRdIn != '0)) begin
            pend_d[IssueRdIn] = 1'b1;
        end
    end

    // NOTE: the register array is cleared on reset because software may read
    // registers before writing them; this makes it flops rather than an SRAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[WbAddrIn] <= WbDataIn;
            end
            pend_q <= pend_d;
        end
    end

    always_comb begin
        Rs1DataOut = '0;
        if (Rs1AddrIn != '0) begin
            Rs1DataOut = bypass1 ? WbDataIn : regs_q[Rs1AddrIn];
        end
        Rs2DataOut = '0;
        if (Rs2AddrIn != '0) begin
            Rs2DataOut = bypass2 ? WbDataIn : regs_q[Rs2AddrIn];
        end
    end

    assign StallOut = (Rs1UseIn && (Rs1AddrIn != '0) && pend_q[Rs1AddrIn] && !bypass1) ||
                      (Rs2UseIn && (Rs2AddrIn != '0) && pend_q[Rs2AddrIn] && !bypass2);

`ifdef REGFILE_DEBUG_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (wr_en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign DbgDataOut = regs_q[DbgAddrIn];
    assign WbCountOut = count_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile: expectations are queued as stimulus is
// driven and compared against the combinational outputs mid-cycle.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_use, rs2_use;
    logic        iss_en, iss_ld;
    logic [4:0]  iss_rd;
    logic [31:0] rs1_data, rs2_data;
    logic        stall;
`ifdef REGFILE_DEBUG_EN
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [31:0] wb_count;
`endif

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .WbEnIn      (wb_en),
        .WbAddrIn    (wb_addr),
        .WbDataIn    (wb_data),
        .Rs1AddrIn   (rs1_addr),
        .Rs2AddrIn   (rs2_addr),
        .Rs1UseIn    (rs1_use),
        .Rs2UseIn    (rs2_use),
        .IssueEnIn   (iss_en),
        .IssueLoadIn (iss_ld),
        .IssueRdIn   (iss_rd),
        .Rs1DataOut  (rs1_data),
        .Rs2DataOut  (rs2_data),
        .StallOut    (stall)
`ifdef REGFILE_DEBUG_EN
        ,
        .DbgAddrIn   (dbg_addr),
        .DbgDataOut  (dbg_data),
        .WbCountOut  (wb_count)
`endif
    );

    typedef enum int {SEL_RS1, SEL_RS2, SEL_STALL, SEL_DBG, SEL_CNT} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                         input logic ie, input logic il, input logic [4:0] rd);
        @(negedge clk);
        rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
        rs1_addr = a1; rs2_addr = a2; rs1_use = u1; rs2_use = u2;
        iss_en = ie; iss_ld = il; iss_rd = rd;
        #1;
    endtask

    task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_sb();
        sb_entry_t   e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RS1:   obs = rs1_data;
                SEL_RS2:   obs = rs2_data;
                SEL_STALL: obs = {31'b0, stall};
`ifdef REGFILE_DEBUG_EN
                SEL_DBG:   obs = dbg_data;
                SEL_CNT:   obs = wb_count;
`endif
                default:   obs = 'x;
            endcase
            n_total++;
            assert (obs === e.exp) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then fill every register and mark every register load-pending.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) begin
            drive(0, 1, 5'(i), $urandom, 0, 0, 0, 0, 1, 1, 5'(i));
        end
        // Reset for two cycles; the writeback and load issued in the first reset cycle must be discarded.
        drive(1, 1, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1, 5);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 5, 5, 1, 1, 0, 0, 0);
        expect_val("rst_rs1_x5", SEL_RS1, 32'h0);
        expect_val("rst_stall_x5", SEL_STALL, 32'h0);
        check_sb();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 1, 0, 0, 0);
            expect_val($sformatf("rst_rs1_x%0d", i), SEL_RS1, 32'h0);
            expect_val($sformatf("rst_rs2_x%0d", 31 - i), SEL_RS2, 32'h0);
            expect_val($sformatf("rst_pend_x%0d", i), SEL_STALL, 32'h0);
            check_sb();
        end

        // Write then read next cycle; x0 writes are discarded.
        drive(0, 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h0000_1234, 7, 0, 1, 1, 0, 0, 0);
        expect_val("rd_x7", SEL_RS1, 32'hDEAD_BEEF);
        expect_val("x0_bypass", SEL_RS2, 32'h0);
        check_sb();
        drive(0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0);
        expect_val("rd_x7_again", SEL_RS1, 32'hDEAD_BEEF);
        expect_val("rd_x0_after_wr", SEL_RS2, 32'h0);
        check_sb();

        // Same-cycle write-first bypass on both ports, then stored value.
        drive(0, 1, 3, 32'hA5A5_A5A5, 3, 3, 1, 1, 0, 0, 0);
        expect_val("byp_rs1", SEL_RS1, 32'hA5A5_A5A5);
        expect_val("byp_rs2", SEL_RS2, 32'hA5A5_A5A5);
        check_sb();
        drive(0, 0, 0, 0, 3, 7, 1, 1, 0, 0, 0);
        expect_val("stored_x3", SEL_RS1, 32'hA5A5_A5A5);
        expect_val("stored_x7", SEL_RS2, 32'hDEAD_BEEF);
        check_sb();

        // Load-use on rs2.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
        drive(0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
        expect_val("lu_rs2_stall", SEL_STALL, 32'h1);
        check_sb();
        drive(0, 0, 0, 0, 9, 9, 0, 0, 0, 0, 0);
        expect_val("lu_unused_nostall", SEL_STALL, 32'h0);
        check_sb();
        drive(0, 1, 9, 32'h55, 0, 9, 0, 1, 0, 0, 0);
        expect_val("lu_wb_nostall", SEL_STALL, 32'h0);
        expect_val("lu_wb_data", SEL_RS2, 32'h55);
        check_sb();
        drive(0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
        expect_val("lu_cleared", SEL_STALL, 32'h0);
        expect_val("lu_stored", SEL_RS2, 32'h55);
        check_sb();

        // Load-use on rs1; non-load issue does not mark pending.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12);
        drive(0, 0, 0, 0, 12, 0, 1, 1, 1, 0, 10);
        expect_val("lu_rs1_stall", SEL_STALL, 32'h1);
        check_sb();
        drive(0, 0, 0, 0, 10, 0, 1, 1, 0, 0, 0);
        expect_val("nonload_nostall", SEL_STALL, 32'h0);
        check_sb();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        expect_val("src0_nostall", SEL_STALL, 32'h0);
        check_sb();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        expect_val("x0_never_pending", SEL_STALL, 32'h0);
        check_sb();

        // Set/clear collision on x4: set wins.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 1, 4, 32'h44, 4, 0, 1, 0, 1, 1, 4);
        expect_val("coll_byp_nostall", SEL_STALL, 32'h0);
        expect_val("coll_byp_data", SEL_RS1, 32'h44);
        check_sb();
        drive(0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0);
        expect_val("coll_still_pend", SEL_STALL, 32'h1);
        expect_val("coll_stored", SEL_RS1, 32'h44);
        check_sb();
        drive(0, 1, 4, 32'h45, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 4, 4, 1, 1, 0, 0, 0);
        expect_val("coll_cleared", SEL_STALL, 32'h0);
        expect_val("coll_new_data", SEL_RS2, 32'h45);
        check_sb();

`ifdef REGFILE_DEBUG_EN
        // Counter counts only nonzero-register writes; debug read has no bypass.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h1111, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h2222, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 2, 32'h3333, 0, 0, 0, 0, 0, 0, 0);
        dbg_addr = 2;
        drive(0, 1, 2, 32'h4444, 0, 0, 0, 0, 0, 0, 0);
        expect_val("dbg_count", SEL_CNT, 32'd2);
        expect_val("dbg_raw_no_bypass", SEL_DBG, 32'h3333);
        check_sb();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_val("dbg_count_3", SEL_CNT, 32'd3);
        expect_val("dbg_raw_x2", SEL_DBG, 32'h4444);
        check_sb();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
